// File: rtl/uart_frame_ctrl.sv
// Frame parser between the UART byte receiver and the payload write path.
// Decodes SOF/addr/len/payload/checksum, issues one command per frame and reports errors.
module uart_frame_ctrl #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned MAX_LEN        = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] cmd_addr,
  output logic [15:0] cmd_len,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_last,
  input  logic        pay_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [7:0]  drop_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN_W = 17'(MAX_LEN);
  localparam logic [2:0] E_LEN = 3'd1, E_CSUM = 3'd2, E_TMO = 3'd3, E_OVR = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_CMD, S_PAYLOAD, S_CSUM} state_e;

  state_e        state_q, state_d, st;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d, len_new;
  logic [15:0]   cnt_q, cnt_d, cnt;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d, csum_byte_q, csum_byte_d, chk_byte;
  logic          csum_pend_q, csum_pend_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    pay_data_q, pay_data_d;
  logic          pay_valid_q, pay_valid_d, pay_last_q, pay_last_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic [2:0]    code_q, code_d, abort_code;
  logic [7:0]    drop_q, drop_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          hand, abort, do_check;

  assign len_new = {len_q[7:0], rx_data};
  assign hand    = pay_valid_q && pay_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    csum_byte_d = csum_byte_q;
    csum_pend_d = csum_pend_q;
    cmd_valid_d = cmd_valid_q;
    pay_data_d  = pay_data_q;
    pay_valid_d = pay_valid_q;
    pay_last_d  = pay_last_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    drop_d      = drop_q;
    abort       = 1'b0;
    abort_code  = 3'd0;
    do_check    = 1'b0;
    chk_byte    = rx_data;
    st          = state_q;
    cnt         = cnt_q;

    // Waiting on downstream (CMD or a pending payload byte) is not a host stall.
    if (rx_valid || state_q == S_IDLE) tmo_d = '0;
    else if (state_q == S_CMD || pay_valid_q) tmo_d = tmo_q;
    else if (tmo_q == TMO_LAST) begin
      tmo_d      = '0;
      abort      = 1'b1;
      abort_code = E_TMO;
    end else tmo_d = tmo_q + TW'(1);

    // A byte arriving on the command handshake cycle belongs to the next state.
    if (state_q == S_CMD && cmd_ready) begin
      cmd_valid_d = 1'b0;
      cnt         = len_q;
      cnt_d       = len_q;
      st          = (len_q == 16'd0) ? S_CSUM : S_PAYLOAD;
      state_d     = st;
    end

    case (st)
      S_IDLE: if (rx_valid) begin
        if (rx_data == SOF_BYTE) begin
          state_d = S_ADDR;
          csum_d  = 8'd0;
          idx_d   = 2'd0;
        end else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      S_ADDR: if (rx_valid) begin
        addr_d = {addr_q[23:0], rx_data};
        csum_d = csum_q ^ rx_data;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_LEN;
          idx_d   = 2'd0;
        end
      end
      S_LEN: if (rx_valid) begin
        len_d  = len_new;
        csum_d = csum_q ^ rx_data;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd1) begin
          idx_d = 2'd0;
          if ({1'b0, len_new} > MAX_LEN_W) begin
            abort      = 1'b1;
            abort_code = E_LEN;
          end else begin
            state_d     = S_CMD;
            cmd_valid_d = 1'b1;
          end
        end
      end
      S_CMD: if (rx_valid) begin
        abort      = 1'b1;
        abort_code = E_OVR;
      end
      S_PAYLOAD: begin
        if (hand) begin
          pay_valid_d = 1'b0;
          pay_last_d  = 1'b0;
        end
        if (rx_valid && cnt != 16'd0) begin
          if (pay_valid_q && !pay_ready) begin
            abort      = 1'b1;
            abort_code = E_OVR;
          end else begin
            pay_data_d  = rx_data;
            pay_valid_d = 1'b1;
            pay_last_d  = (cnt == 16'd1);
            cnt_d       = cnt - 16'd1;
            csum_d      = csum_q ^ rx_data;
          end
        end else if (hand && pay_last_q) begin
          if (rx_valid) do_check = 1'b1;
          else if (csum_pend_q) begin
            do_check = 1'b1;
            chk_byte = csum_byte_q;
          end else state_d = S_CSUM;
        end else if (rx_valid) begin
          // All payload received but the last byte is still pending: hold the checksum.
          if (csum_pend_q) begin
            abort      = 1'b1;
            abort_code = E_OVR;
          end else begin
            csum_byte_d = rx_data;
            csum_pend_d = 1'b1;
          end
        end
      end
      S_CSUM: if (rx_valid) do_check = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (do_check) begin
      state_d     = S_IDLE;
      csum_pend_d = 1'b0;
      if (chk_byte == csum_q) ok_d = 1'b1;
      else begin
        abort      = 1'b1;
        abort_code = E_CSUM;
      end
    end

    if (abort) begin
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      pay_valid_d = 1'b0;
      pay_last_d  = 1'b0;
      csum_pend_d = 1'b0;
      idx_d       = 2'd0;
      ok_d        = 1'b0;
      err_d       = 1'b1;
      code_d      = abort_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      csum_byte_q <= '0;
      csum_pend_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
      drop_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      csum_byte_q <= csum_byte_d;
      csum_pend_q <= csum_pend_d;
      cmd_valid_q <= cmd_valid_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_last_q  <= pay_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      code_q      <= code_d;
      drop_q      <= drop_d;
      tmo_q       <= tmo_d;
    end
  end

  assign cmd_addr  = addr_q;
  assign cmd_len   = len_q;
  assign cmd_valid = cmd_valid_q;
  assign pay_data  = pay_data_q;
  assign pay_valid = pay_valid_q;
  assign pay_last  = pay_last_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign drop_cnt  = drop_q;
endmodule
